fu_tag_reg_bank: RTL



---
 rtl/fu_tag_reg_bank_if.sv | 29 ++
 rtl/fu_tag_reg_bank.sv | 103 ++++++++++
 2 files changed

// File: rtl/fu_tag_reg_bank_if.sv
// Request/observation bundle for the per-wavefront FU tag store.
// Requests carry no ready: every cycle with a valid set is accepted and completes one edge later.
interface fu_tag_reg_bank_if #(
    parameter int NUM_WF  = 40,
    parameter int WF_ID_W = 6,
    parameter int NUM_FU  = 4,
    parameter int FU_W    = 2,
    parameter int CNT_W   = 6
);
    logic                      f_decode_valid;
    logic [FU_W-1:0]           f_decode_fu;
    logic [WF_ID_W-1:0]        f_decode_wfid;
    logic                      retire_valid;
    logic [WF_ID_W-1:0]        retire_wfid;
    logic [NUM_WF-1:0]         tag_valid;
    logic [NUM_FU*NUM_WF-1:0]  fu_vec;
    logic [NUM_FU*CNT_W-1:0]   fu_occupancy;
    logic                      err_pulse;

    modport master (
        output f_decode_valid, f_decode_fu, f_decode_wfid, retire_valid, retire_wfid,
        input  tag_valid, fu_vec, fu_occupancy, err_pulse
    );

    modport slave (
        input  f_decode_valid, f_decode_fu, f_decode_wfid, retire_valid, retire_wfid,
        output tag_valid, fu_vec, fu_occupancy, err_pulse
    );
endinterface

// File: rtl/fu_tag_reg_bank.sv
// Per-wavefront FU tag store: decode writes a tag, retire clears it, and
// registered per-FU occupancy counters track how many valid slots carry each tag.
module fu_tag_reg_bank #(
    parameter int NUM_WF  = 40,
    parameter int WF_ID_W = 6,
    parameter int NUM_FU  = 4,
    parameter int FU_W    = 2,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    fu_tag_reg_bank_if.slave  bus
);
    localparam logic [WF_ID_W:0] WF_LIM = (WF_ID_W+1)'(NUM_WF);
    localparam logic [FU_W:0]    FU_LIM = (FU_W+1)'(NUM_FU);

    logic [NUM_WF-1:0] vld_q, vld_d;
    logic [FU_W-1:0]   tag_q [NUM_WF];
    logic [FU_W-1:0]   tag_d [NUM_WF];
    logic [CNT_W-1:0]  cnt_q [NUM_FU];
    logic [CNT_W-1:0]  cnt_d [NUM_FU];
    logic              err_q, err_d;

    logic              dec_ok, ret_in, coll, ret_ok;
    logic              dec_old_vld, ret_old_vld;
    logic [FU_W-1:0]   dec_old_tag, ret_old_tag;

    always_comb begin
        dec_ok = bus.f_decode_valid
              && ({1'b0, bus.f_decode_wfid} < WF_LIM)
              && ({1'b0, bus.f_decode_fu} < FU_LIM);
        ret_in = bus.retire_valid && ({1'b0, bus.retire_wfid} < WF_LIM);
        coll   = dec_ok && ret_in && (bus.retire_wfid == bus.f_decode_wfid);

        // Out-of-range ids match no slot, so their lookups read as invalid.
        dec_old_vld = 1'b0;
        dec_old_tag = '0;
        ret_old_vld = 1'b0;
        ret_old_tag = '0;
        for (int w = 0; w < NUM_WF; w++) begin
            if (bus.f_decode_wfid == WF_ID_W'(w)) begin
                dec_old_vld = vld_q[w];
                dec_old_tag = tag_q[w];
            end
            if (bus.retire_wfid == WF_ID_W'(w)) begin
                ret_old_vld = vld_q[w];
                ret_old_tag = tag_q[w];
            end
        end

        // A retire colliding with a legal decode is absorbed by the decode.
        ret_ok = ret_in && ret_old_vld && !coll;
        err_d  = (bus.f_decode_valid && !dec_ok)
              || (bus.retire_valid && !coll && !(ret_in && ret_old_vld));

        vld_d = vld_q;
        tag_d = tag_q;
        for (int w = 0; w < NUM_WF; w++) begin
            if (ret_ok && bus.retire_wfid == WF_ID_W'(w)) begin
                vld_d[w] = 1'b0;
            end
            if (dec_ok && bus.f_decode_wfid == WF_ID_W'(w)) begin
                vld_d[w] = 1'b1;
                tag_d[w] = bus.f_decode_fu;
            end
        end

        for (int f = 0; f < NUM_FU; f++) begin
            cnt_d[f] = cnt_q[f]
                     + CNT_W'(dec_ok && bus.f_decode_fu == FU_W'(f))
                     - CNT_W'(dec_ok && dec_old_vld && dec_old_tag == FU_W'(f))
                     - CNT_W'(ret_ok && ret_old_tag == FU_W'(f));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int w = 0; w < NUM_WF; w++) tag_q[w] <= '0;
            for (int f = 0; f < NUM_FU; f++) cnt_q[f] <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int w = 0; w < NUM_WF; w++) tag_q[w] <= tag_d[w];
            for (int f = 0; f < NUM_FU; f++) cnt_q[f] <= cnt_d[f];
        end
    end

    always_comb begin
        bus.fu_vec       = '0;
        bus.fu_occupancy = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            bus.fu_occupancy[f*CNT_W +: CNT_W] = cnt_q[f];
            for (int w = 0; w < NUM_WF; w++) begin
                bus.fu_vec[f*NUM_WF+w] = vld_q[w] && (tag_q[w] == FU_W'(f));
            end
        end
    end

    assign bus.tag_valid = vld_q;
    assign bus.err_pulse = err_q;
endmodule
